// File: rtl/seg_pkg.sv
// Seven-segment patterns (active-low, bit order {g,f,e,d,c,b,a}) and scan FSM encodings
// shared by the scan capture block and its decoder.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_e;

  function automatic logic [3:0] low_count(input logic [7:0] an);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, ~an[i]};
    return n;
  endfunction

  // Only meaningful when exactly one anode is low.
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (!an[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low seven-segment pattern into a BCD value,
// flagging blanks (not valid) and unrecognised patterns (error).
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       valid_o,
  output logic       err_o
);

  always_comb begin
    value_o = 4'hF;
    valid_o = 1'b1;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     value_o = 4'd0;
      SEG_1:     value_o = 4'd1;
      SEG_2:     value_o = 4'd2;
      SEG_3:     value_o = 4'd3;
      SEG_4:     value_o = 4'd4;
      SEG_5:     value_o = 4'd5;
      SEG_6:     value_o = 4'd6;
      SEG_7:     value_o = 4'd7;
      SEG_8:     value_o = 4'd8;
      SEG_9:     value_o = 4'd9;
      SEG_BLANK: valid_o = 1'b0;
      default: begin
        valid_o = 1'b0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Snoops a multiplexed 8-digit seven-segment bus and captures each digit once its
// anode/cathode pattern has been stable for SETTLE_CYCLES samples.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no single anode selected; waiting for a one-hot anode
// SETTLE   | one-hot anode seen; counting identical consecutive samples
// CAPTURE  | pattern settled; write nibble/valid/seg_err, pulse update
// HOLD     | digit captured; wait for any input change before re-arming
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [7:0]  anodes,
  input  logic [6:0]  cathodes,
  output logic [31:0] digits,
  output logic [7:0]  valid,
  output logic [7:0]  seg_err,
  output logic        update,
  output logic [2:0]  upd_idx,
  output logic        overlap
);

  localparam logic [15:0] SETTLE_TC = 16'(SETTLE_CYCLES);

  logic [7:0]  an_q;
  logic [6:0]  cat_q;
  logic [14:0] sample;
  logic [14:0] prev_q;
  scan_state_e state_q;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [31:0] digits_q;
  logic [7:0]  valid_q;
  logic [7:0]  err_q;
  logic        update_q;
  logic [2:0]  upd_idx_q;
  logic        overlap_q;

  logic        one_hot;
  logic        multi_low;
  logic        changed;
  logic [2:0]  cap_idx;
  logic [3:0]  dec_value;
  logic        dec_valid;
  logic        dec_err;

  assign sample    = {an_q, cat_q};
  assign one_hot   = (low_count(an_q) == 4'd1);
  assign multi_low = (low_count(an_q) > 4'd1);
  assign changed   = (sample != prev_q);
  assign count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign cap_idx   = low_index(prev_q[14:7]);

  // In CAPTURE, prev_q still holds the settled sample, so decode from it.
  seg7_to_bcd u_dec (
    .seg_i   (prev_q[6:0]),
    .value_o (dec_value),
    .valid_o (dec_valid),
    .err_o   (dec_err)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      an_q      <= '1;
      cat_q     <= '1;
      prev_q    <= '1;
      state_q   <= ST_IDLE;
      count_q   <= '0;
      digits_q  <= '1;
      valid_q   <= '0;
      err_q     <= '0;
      update_q  <= 1'b0;
      upd_idx_q <= '0;
      overlap_q <= 1'b0;
    end else begin
      an_q     <= anodes;
      cat_q    <= cathodes;
      prev_q   <= sample;
      update_q <= 1'b0;
      if (multi_low) overlap_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (one_hot) begin
            state_q <= ST_SETTLE;
            count_q <= 16'd1;
          end
        end
        ST_SETTLE: begin
          if (!changed) begin
            count_q <= count_d;
            if (count_d == SETTLE_TC) state_q <= ST_CAPTURE;
          end else if (one_hot) begin
            count_q <= 16'd1;
          end else begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        end
        ST_CAPTURE: begin
          digits_q[{cap_idx, 2'b00} +: 4] <= dec_value;
          valid_q[cap_idx]                <= dec_valid;
          err_q[cap_idx]                  <= dec_err;
          update_q                        <= 1'b1;
          upd_idx_q                       <= cap_idx;
          // A change landing in this cycle re-arms now instead of slipping past HOLD.
          if (!changed) begin
            state_q <= ST_HOLD;
          end else if (one_hot) begin
            state_q <= ST_SETTLE;
            count_q <= 16'd1;
          end else begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        end
        ST_HOLD: begin
          if (changed) begin
            if (one_hot) begin
              state_q <= ST_SETTLE;
              count_q <= 16'd1;
            end else begin
              state_q <= ST_IDLE;
              count_q <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign digits  = digits_q;
  assign valid   = valid_q;
  assign seg_err = err_q;
  assign update  = update_q;
  assign upd_idx = upd_idx_q;
  assign overlap = overlap_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios then random segments, every cycle
// compared against a run-length reference model of the capture rules.
module tb_seg_scan_capture;

  localparam int N = 16;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic [7:0]  anodes     = 8'hFF;
  logic [6:0]  cathodes   = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  valid;
  logic [7:0]  seg_err;
  logic        update;
  logic [2:0]  upd_idx;
  logic        overlap;

  seg_scan_capture #(.SETTLE_CYCLES(N)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .digits     (digits),
    .valid      (valid),
    .seg_err    (seg_err),
    .update     (update),
    .upd_idx    (upd_idx),
    .overlap    (overlap)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks     = 0;
  int n_pass       = 0;
  int cyc          = 0;
  int upd_cnt      = 0;
  int last_upd_cyc = -1;
  int rel_cyc      = 0;

  // Reference model: expected outputs, current input run, and pending effects by cycle.
  logic [31:0] e_digits;
  logic [7:0]  e_valid;
  logic [7:0]  e_err;
  logic        e_upd;
  logic [2:0]  e_idx;
  logic        e_ov;
  logic        prev_rst = 1'b1;
  logic [14:0] run_val  = '0;
  int          run_len  = 0;
  logic        pc_en  [4];
  logic [7:0]  pc_an  [4];
  logic [6:0]  pc_cat [4];
  logic        po_en  [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int n_low(input logic [7:0] an);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) n++;
    return n;
  endfunction

  function automatic int low_pos(input logic [7:0] an);
    int p = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) p = i;
    return p;
  endfunction

  function automatic void ref_decode(input logic [6:0] c, output logic [3:0] v,
                                     output logic ok, output logic er);
    v  = 4'hF;
    ok = 1'b0;
    er = (c != 7'h7F);
    for (int i = 0; i < 10; i++) begin
      if (c == PAT[i]) begin
        v  = 4'(i);
        ok = 1'b1;
        er = 1'b0;
      end
    end
  endfunction

  task automatic model_edge();
    int s;
    int p;
    logic [3:0] v;
    logic ok;
    logic er;
    s = cyc % 4;
    if (prev_rst) begin
      e_digits = '1;
      e_valid  = '0;
      e_err    = '0;
      e_upd    = 1'b0;
      e_idx    = '0;
      e_ov     = 1'b0;
      for (int i = 0; i < 4; i++) begin
        pc_en[i] = 1'b0;
        po_en[i] = 1'b0;
      end
    end else begin
      e_upd = 1'b0;
      if (pc_en[s]) begin
        ref_decode(pc_cat[s], v, ok, er);
        p = low_pos(pc_an[s]);
        e_digits[p*4 +: 4] = v;
        e_valid[p] = ok;
        e_err[p]   = er;
        e_upd      = 1'b1;
        e_idx      = 3'(p);
        pc_en[s]   = 1'b0;
      end
      if (po_en[s]) begin
        e_ov     = 1'b1;
        po_en[s] = 1'b0;
      end
    end
  endtask

  // A one-hot input value held for N cycles starting at cycle s shows its update in cycle s+N+2;
  // a multi-low anode sample shows overlap two cycles later.
  task automatic model_sample(input logic r, input logic [7:0] an, input logic [6:0] cat);
    int s;
    prev_rst = r;
    if (r) begin
      run_len = 0;
    end else begin
      if (run_len > 0 && {an, cat} == run_val) run_len++;
      else begin
        run_val = {an, cat};
        run_len = 1;
      end
      if (n_low(an) == 1 && run_len == N) begin
        s = (cyc + 3) % 4;
        pc_en[s]  = 1'b1;
        pc_an[s]  = an;
        pc_cat[s] = cat;
      end
      if (n_low(an) >= 2) po_en[(cyc + 2) % 4] = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic [7:0] an, input logic [6:0] cat);
    @(posedge clk_100MHz);
    model_edge();
    #1;
    reset    = r;
    anodes   = an;
    cathodes = cat;
    @(negedge clk_100MHz);
    check("digits",  digits,           e_digits);
    check("valid",   32'(valid),       32'(e_valid));
    check("seg_err", 32'(seg_err),     32'(e_err));
    check("update",  32'(update),      32'(e_upd));
    if (e_upd) check("upd_idx", 32'(upd_idx), 32'(e_idx));
    check("overlap", 32'(overlap),     32'(e_ov));
    if (update) begin
      upd_cnt++;
      last_upd_cyc = cyc;
    end
    model_sample(r, an, cat);
    cyc++;
  endtask

  task automatic hold(input int n, input logic [7:0] an, input logic [6:0] cat);
    for (int i = 0; i < n; i++) step(1'b0, an, cat);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 7'h7F);
    check("rst_digits", digits, 32'hFFFF_FFFF);

    // Digit 0 shows "3" steadily.
    upd_cnt = 0;
    hold(20, 8'hFE, 7'h30);
    check("t1_upd_cnt", 32'(upd_cnt), 32'd1);
    check("t1_dig0",    32'(digits[3:0]), 32'h3);
    check("t1_valid0",  32'(valid[0]), 32'd1);
    check("t1_idx",     32'(upd_idx), 32'd0);

    // Digit 2 with cathodes flipping every 8 cycles never settles.
    upd_cnt = 0;
    for (int k = 0; k < 8; k++) hold(8, 8'hFB, (k % 2 == 0) ? 7'h40 : 7'h79);
    check("t2_upd_cnt", 32'(upd_cnt), 32'd0);
    check("t2_digits",  digits, 32'hFFFF_FFF3);

    // Digit 3 blank, then an undecodable pattern.
    upd_cnt = 0;
    hold(20, 8'hF7, 7'h7F);
    check("t3_upd_cnt", 32'(upd_cnt), 32'd1);
    check("t3_dig3",    32'(digits[15:12]), 32'hF);
    check("t3_valid3",  32'(valid[3]), 32'd0);
    check("t3_err3a",   32'(seg_err[3]), 32'd0);
    check("t3_idx",     32'(upd_idx), 32'd3);
    hold(20, 8'hF7, 7'h55);
    check("t3_err3b",   32'(seg_err[3]), 32'd1);
    check("t3_upd_cnt2", 32'(upd_cnt), 32'd2);

    // Slow scan of two digits.
    upd_cnt = 0;
    hold(10000, 8'hFE, 7'h79);
    hold(10000, 8'hFD, 7'h24);
    check("t4_upd_cnt", 32'(upd_cnt), 32'd2);
    check("t4_dig10",   32'(digits[7:0]), 32'h21);
    check("t4_valid",   32'(valid), 32'h03);

    // Single-cycle overlap on digits 0 and 1.
    upd_cnt = 0;
    step(1'b0, 8'hFC, 7'h00);
    hold(20, 8'hFF, 7'h00);
    check("t5_overlap", 32'(overlap), 32'd1);
    check("t5_upd_cnt", 32'(upd_cnt), 32'd0);
    check("t5_dig10",   32'(digits[7:0]), 32'h21);

    // Reset pulse while settling digit 0 at count 10.
    hold(11, 8'hFE, 7'h00);
    check("t6_ov_held", 32'(overlap), 32'd1);
    upd_cnt = 0;
    step(1'b1, 8'hFE, 7'h00);
    rel_cyc = cyc;
    step(1'b0, 8'hFE, 7'h00);
    check("t6_rst_digits", digits, 32'hFFFF_FFFF);
    check("t6_rst_ov",     32'(overlap), 32'd0);
    hold(29, 8'hFE, 7'h00);
    check("t6_upd_cnt", 32'(upd_cnt), 32'd1);
    check("t6_latency", 32'(last_upd_cyc - rel_cyc), 32'(N + 2));
    check("t6_dig0",    32'(digits[3:0]), 32'h8);

    // Random segments around the settle boundary, with occasional reset.
    for (int k = 0; k < 400; k++) begin
      int sel;
      int len;
      logic [7:0] an;
      logic [6:0] cat;
      sel = $urandom_range(0, 99);
      if (sel < 80)      an = ~(8'h01 << $urandom_range(0, 7));
      else if (sel < 90) an = 8'hFF;
      else               an = 8'($urandom);
      sel = $urandom_range(0, 99);
      if (sel < 70)      cat = PAT[$urandom_range(0, 9)];
      else if (sel < 80) cat = 7'h7F;
      else               cat = 7'($urandom);
      sel = $urandom_range(0, 99);
      if (sel < 50)      len = $urandom_range(N - 2, N + 3);
      else if (sel < 75) len = $urandom_range(1, 4);
      else               len = $urandom_range(20, 40);
      if ($urandom_range(0, 29) == 0) begin
        for (int j = 0; j < $urandom_range(1, 2); j++) step(1'b1, an, cat);
      end
      hold(len, an, cat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
